// File: rtl/latch_event_logger_pkg.sv
// Shared widths, defaults and the event record layout {level, time}, so the
// logger and any monitor/stimulus code decode events identically.
package latch_event_logger_pkg;

   localparam int TS_W_DEF        = 16;
   localparam int DEPTH_DEF       = 8;
   localparam int SYNC_STAGES_DEF = 2;

   // Event record at default width: level sits in the MSB, timestamp below it.
   typedef struct packed {
      logic                level;
      logic [TS_W_DEF-1:0] tstamp;
   } ev_rec_t;

   localparam int EV_LEVEL_BIT = TS_W_DEF;

   // Width of one stored event for a given timestamp width.
   function automatic int ev_width(input int ts_w);
      return ts_w + 1;
   endfunction

endpackage

// File: rtl/latch_event_logger_event_fifo.sv
// Generic show-ahead synchronous FIFO. The head slot is presented
// combinationally on dout and reads 0 while empty. A push into a full FIFO
// is accepted only when a pop happens on the same edge.
module event_fifo #(
   parameter int WIDTH = 17,
   parameter int DEPTH = 8
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [DEPTH-1:0][WIDTH-1:0] mem;
   logic [AW-1:0]               wr_ptr;
   logic [AW-1:0]               rd_ptr;
   logic                        pop_ok;
   logic                        push_ok;

   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign pop_ok  = pop & ~empty;
   assign push_ok = push & (~full | pop_ok);
   assign dout    = empty ? '0 : mem[rd_ptr];

   // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
   always_ff @(posedge clock) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage write; contents need no reset since count gates visibility.
   always_ff @(posedge clock) begin
      if (push_ok) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/latch_event_logger.sv
// Logs every transition of an asynchronous latch output: synchronises q_in,
// detects edges, timestamps them and queues {level, time} for a consumer.
module latch_event_logger
   import latch_event_logger_pkg::*;
#(
   parameter int TS_W        = TS_W_DEF,
   parameter int DEPTH       = DEPTH_DEF,
   parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   q_in,
   input  logic                   log_en,
   output logic                   ev_valid,
   input  logic                   ev_ready,
   output logic                   ev_level,
   output logic [TS_W-1:0]        ev_time,
   output logic [$clog2(DEPTH):0] ev_count,
   output logic                   overflow,
   input  logic                   ovf_clr
);

   localparam int EW = ev_width(TS_W);

   typedef struct packed {
      logic            level;
      logic [TS_W-1:0] tstamp;
   } ev_t;

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   s_q;
   logic                   prev_q;
   logic [TS_W-1:0]        ts;
   logic                   evt;
   logic                   pop;
   logic                   push;
   logic                   drop;
   logic                   full;
   logic                   empty;
   ev_t                    wr_ev;
   ev_t                    head;

   assign s_q      = sync_q[SYNC_STAGES-1];
   assign evt      = log_en & (s_q ^ prev_q);
   assign ev_valid = ~empty;
   assign pop      = ev_valid & ev_ready;
   assign push     = evt & (~full | pop);
   assign drop     = evt & full & ~pop;

   assign wr_ev.level  = s_q;
   assign wr_ev.tstamp = ts;
   assign ev_level     = head.level;
   assign ev_time      = head.tstamp;

   // Synchroniser shift chain for the asynchronous latch output.
   always_ff @(posedge clock) begin
      if (!reset) sync_q <= '0;
      else        sync_q <= {sync_q[SYNC_STAGES-2:0], q_in};
   end

   // prev_q tracks s_q unconditionally so re-enabling never fakes an edge;
   // ts advances only while logging is enabled and wraps silently.
   always_ff @(posedge clock) begin
      if (!reset) begin
         prev_q <= 1'b0;
         ts     <= '0;
      end else begin
         prev_q <= s_q;
         if (log_en) ts <= ts + 1'b1;
      end
   end

   // Sticky drop flag; a drop on the same edge as a clear keeps it set.
   always_ff @(posedge clock) begin
      if (!reset)       overflow <= 1'b0;
      else if (drop)    overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
   end

   event_fifo #(
      .WIDTH (EW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clock (clock),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .din   (wr_ev),
      .dout  (head),
      .count (ev_count),
      .full  (full),
      .empty (empty)
   );

endmodule

// File: tb/tb_latch_event_logger.sv
// Bench for latch_event_logger: two instances (16-bit and 4-bit timestamps)
// share stimulus and are compared every cycle against a queue-based model.
module tb_latch_event_logger;

   localparam int DEPTH = 8;
   localparam int SYNC  = 2;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic          clock = 1'b0;
   logic          reset, q_in, log_en, ev_ready, ovf_clr;
   logic          ev_valid, ev_level, overflow;
   logic [15:0]   ev_time;
   logic [CW-1:0] ev_count;
   logic          ev_valid4, ev_level4, overflow4;
   logic [3:0]    ev_time4;
   logic [CW-1:0] ev_count4;

   int n_assert = 0;
   int n_fail   = 0;

   // Model state: delay line of q_in samples, last seen level, timestamp, queue.
   bit              hist[$];
   bit              m_prev;
   int unsigned     m_ts;
   bit [32:0]       m_q[$];
   bit              m_ovf;
   int unsigned     seen_t[$];

   always #5 clock = ~clock;

   latch_event_logger #(.TS_W(16), .DEPTH(DEPTH), .SYNC_STAGES(SYNC)) u_dut (
      .clock(clock), .reset(reset), .q_in(q_in), .log_en(log_en),
      .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_level(ev_level),
      .ev_time(ev_time), .ev_count(ev_count), .overflow(overflow),
      .ovf_clr(ovf_clr));

   latch_event_logger #(.TS_W(4), .DEPTH(DEPTH), .SYNC_STAGES(SYNC)) u_dut4 (
      .clock(clock), .reset(reset), .q_in(q_in), .log_en(log_en),
      .ev_valid(ev_valid4), .ev_ready(ev_ready), .ev_level(ev_level4),
      .ev_time(ev_time4), .ev_count(ev_count4), .overflow(overflow4),
      .ovf_clr(ovf_clr));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_assert++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   // Apply one clock edge to the model using the inputs held across it.
   task automatic model_edge();
      bit sq, evt, pop, full;
      if (!reset) begin
         hist = {};
         repeat (SYNC) hist.push_back(1'b0);
         m_prev = 1'b0; m_ts = 0; m_q = {}; m_ovf = 1'b0;
      end else begin
         sq   = hist[SYNC-1];
         evt  = log_en && (sq != m_prev);
         pop  = (m_q.size() != 0) && ev_ready;
         full = (m_q.size() == DEPTH);
         if (pop) void'(m_q.pop_front());
         if (evt && (!full || pop)) m_q.push_back({sq, m_ts});
         if (evt && full && !pop) m_ovf = 1'b1;
         else if (ovf_clr)        m_ovf = 1'b0;
         m_prev = sq;
         if (log_en) m_ts++;
         hist.push_front(q_in);
         void'(hist.pop_back());
      end
   endtask

   task automatic step();
      bit [32:0] head;
      @(posedge clock);
      model_edge();
      #1;
      head = (m_q.size() != 0) ? m_q[0] : 33'd0;
      chk("ev_valid",  ev_valid,   m_q.size() != 0);
      chk("ev_level",  ev_level,   head[32]);
      chk("ev_time",   ev_time,    head[15:0]);
      chk("ev_count",  ev_count,   m_q.size());
      chk("overflow",  overflow,   m_ovf);
      chk("ev_time4",  ev_time4,   head[3:0]);
      chk("ev_count4", ev_count4,  m_q.size());
      chk("overflow4", overflow4,  m_ovf);
   endtask

   initial begin
      reset = 1'b0; q_in = 1'b0; log_en = 1'b0; ev_ready = 1'b0; ovf_clr = 1'b0;

      // Reset with q_in toggling.
      q_in = 1'b1; step();
      q_in = 1'b0; step();
      chk("rst_valid", ev_valid, 0); chk("rst_count", ev_count, 0);
      chk("rst_ovf", overflow, 0);   chk("rst_time", ev_time, 0);

      // Two transitions at edges 10 and 20 logged at 12 and 22.
      reset = 1'b1; log_en = 1'b1;
      for (int e = 0; e < 25; e++) begin
         q_in = (e >= 10 && e < 20);
         step();
      end
      chk("t2_count", ev_count, 2);
      chk("t2_level", ev_level, 1);
      chk("t2_time",  ev_time, 12);

      // Drain, then toggle every 3 cycles with ready held.
      ev_ready = 1'b1;
      repeat (4) step();
      seen_t = {};
      for (int i = 0; i < 24; i++) begin
         if (i % 3 == 0) q_in = ~q_in;
         step();
         chk("t3_cnt_le1", ev_count <= 1, 1);
         if (ev_valid === 1'b1) seen_t.push_back(ev_time);
      end
      repeat (3) step();
      for (int i = 1; i < seen_t.size(); i++)
         chk("t3_delta", seen_t[i] - seen_t[i-1], 3);

      // Nine transitions into an 8-deep FIFO.
      ev_ready = 1'b0;
      for (int i = 0; i < 9; i++) begin
         q_in = ~q_in; step(); step();
      end
      repeat (3) step();
      chk("t4_count", ev_count, 8);
      chk("t4_ovf", overflow, 1);
      // Drop coincident with clear keeps overflow set.
      q_in = ~q_in; step(); step();
      ovf_clr = 1'b1; step(); ovf_clr = 1'b0;
      chk("t4_set_wins", overflow, 1);
      ovf_clr = 1'b1; step(); ovf_clr = 1'b0;
      chk("t4_clr", overflow, 0);

      // Full FIFO: pop and push on the same edge.
      q_in = ~q_in; step(); step();
      ev_ready = 1'b1; step(); ev_ready = 1'b0;
      chk("t5_count", ev_count, 8);
      chk("t5_ovf", overflow, 0);
      ev_ready = 1'b1;
      repeat (10) step();

      // Transition while disabled produces nothing and freezes ts.
      log_en = 1'b0; q_in = ~q_in;
      repeat (4) step();
      log_en = 1'b1;
      repeat (4) step();
      chk("t6_no_evt", ev_count, 0);
      for (int i = 0; i < 20; i++) begin
         if (i % 5 == 0) q_in = ~q_in;
         step();
      end

      // Reset flushes queued events; next event stamped SYNC.
      ev_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         q_in = ~q_in; step(); step();
      end
      repeat (3) step();
      chk("t7_pre", ev_count, 5);
      reset = 1'b0; q_in = 1'b1; step(); reset = 1'b1;
      chk("t7_valid", ev_valid, 0);
      chk("t7_count", ev_count, 0);
      repeat (3) step();
      chk("t7_valid2", ev_valid, 1);
      chk("t7_time", ev_time, SYNC);

      // Randomised traffic.
      for (int i = 0; i < 600; i++) begin
         q_in     = ($urandom_range(0, 2) == 0) ? ~q_in : q_in;
         log_en   = ($urandom_range(0, 7) != 0);
         ev_ready = ($urandom_range(0, 2) == 0);
         ovf_clr  = ($urandom_range(0, 9) == 0);
         reset    = ($urandom_range(0, 149) != 0);
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
